cpu_soc_top: RTL and testbench
==============================

Name: cpu_soc_top

Overview:
- Board-level I/O hub for the MoonCore demo platform.
- Synchronizes the button, switch, timer-interrupt and UART-RX inputs.
- Drives the 4 LEDs according to a switch-selected display mode.
- Reports button changes, timer ticks and status queries as single bytes over an 8N1 UART transmitter. A UART receiver captures host bytes for display and query handling.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit (TX and RX); must be >= 4

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-high (asserted when 1)
int_timer  input  1  external timer interrupt request, asynchronous level
buttom  input  4  push-button bus, asynchronous
switch  input  4  slide-switch bus, asynchronous
led  output  4  LED drive, registered
uart_rx  input  1  UART receive line, idle high, asynchronous
uart_tx  output  1  UART transmit line, idle high, registered

Behaviour:
Reset:
- One clock; reset is synchronous and active-high.
- While rst_n=1, all state clears: led=0, uart_tx=1, tick_cnt=0, rx_byte=0, prev_btn=0, all pending flags=0, TX and RX FSMs in IDLE.
- Synchronizer flops reset to 0, except the uart_rx synchronizer, which resets to 1.

Input synchronization and edge detection:
- int_timer, buttom, switch and uart_rx each pass through a 2-flop synchronizer.
- A timer event is a synchronized 0->1 edge of int_timer. It increments 4-bit tick_cnt (wraps 15->0) and sets timer_pend.
- A button event occurs when synced buttom != prev_btn. prev_btn is then updated, btn_pend is set and btn_val latches the new value.
- Because prev_btn resets to 0, a nonzero buttom at reset release produces an event.
- Latency from a pin change to its pending flag: 3 clocks.

LED mux:
- LED mode is selected by synced switch[1:0], registered one cycle after the mux.
- 00: synced buttom.
- 01: tick_cnt.
- 10: rx_byte[3:0].
- 11: synced buttom XOR synced switch.

UART TX (8N1, LSB first):
- States: IDLE, START, DATA, STOP. Each bit lasts CLKS_PER_BIT clocks.
- In IDLE, one pending source is granted per cycle. Priority: timer > button > query.
- Byte sent per source:
  - timer: {4'hA, tick_cnt}.
  - button: {4'hB, btn_val}.
  - query: {synced switch, synced buttom}, sampled at grant.
- The granted flag clears on grant. A new event on the same source while its flag is set overwrites the payload; only one byte is sent.
- Events arriving during transmission stay pending.
- A frame is 10 bits; uart_tx returns to IDLE high afterwards. Back-to-back frames have 1 idle clock between them.

UART RX:
- States: IDLE, START, DATA, STOP.
- A falling edge on synced rx enters START. The line is resampled at CLKS_PER_BIT/2; if high, the frame is a glitch and the FSM returns to IDLE.
- Data bits are sampled every CLKS_PER_BIT at mid-bit.
- Stop bit sampled 1: rx_byte is updated. If the byte equals 8'h3F, query_pend is set.
- Stop bit sampled 0 (framing error): the byte is discarded and rx_byte keeps its old value.
- The FSM returns to IDLE after the stop-bit sample.

Reset mid-frame:
- TX aborts immediately and uart_tx=1 the next clock. RX drops its partial byte.

Test Plan:
- Reset held 2 clocks, buttom=1, switch=2 -> during reset led=0 and uart_tx=1. After release, UART emits 0xB1 (start bit, bits 1,0,0,0,1,1,0,1, stop bit), each bit 16 clocks. led=0 until the first RX byte, because mode 10 shows rx_byte.
- buttom stepped 1->2->3->4 with 500 ns spacing, switch=0 -> led follows buttom within 4 clocks. UART sends 0xB2, 0xB3, 0xB4 in order. A change arriving mid-frame is sent after the current frame.
- int_timer pulsed 2 clocks, three times -> tick_cnt 1,2,3. With switch=1, led shows 1,2,3. UART sends 0xA1, 0xA2, 0xA3.
- Timer edge and button change in the same cycle -> 0xA_ frame sent first, then 0xB_ frame, separated by 1 idle clock.
- Host sends 0x5C at 16 clocks/bit, switch=2 -> led=4'hC. Host then sends 0x3F with switch=2, buttom=4 -> led=4'hF, UART replies 0x24.
- RX frame with stop bit 0 -> rx_byte unchanged and no reply. A 3-clock low glitch on uart_rx -> ignored. Reset asserted mid-TX -> uart_tx=1 on the next clock and no byte is resumed.

Source files
------------

// File: rtl/cpu_soc_top.sv
// MoonCore board I/O hub: synchronizes board inputs, drives the LEDs and
// reports timer/button/query events as 8N1 UART bytes; captures host bytes.
module cpu_soc_top #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_timer,
    input  logic [3:0] buttom,
    input  logic [3:0] switch,
    output logic [3:0] led,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Two-flop synchronizers; the rx line idles high so its chain resets to 1.
    logic [1:0] tmr_sync_q;
    logic [3:0] btn_s1_q, btn_s2_q;
    logic [3:0] sw_s1_q, sw_s2_q;
    logic [1:0] rx_sync_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tmr_sync_q <= 2'b00;
            btn_s1_q   <= 4'h0;
            btn_s2_q   <= 4'h0;
            sw_s1_q    <= 4'h0;
            sw_s2_q    <= 4'h0;
            rx_sync_q  <= 2'b11;
        end else begin
            tmr_sync_q <= {tmr_sync_q[0], int_timer};
            btn_s1_q   <= buttom;
            btn_s2_q   <= btn_s1_q;
            sw_s1_q    <= switch;
            sw_s2_q    <= sw_s1_q;
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
        end
    end

    logic       tmr_s;
    logic       rx_s;
    assign tmr_s = tmr_sync_q[1];
    assign rx_s  = rx_sync_q[1];

    // Event detection and pending flags
    logic       tmr_prev_q;
    logic [3:0] prev_btn_q;
    logic [3:0] btn_val_q;
    logic [3:0] tick_cnt_q;
    logic       timer_pend_q, btn_pend_q, query_pend_q;
    logic       timer_pend_d, btn_pend_d, query_pend_d;
    logic       timer_evt, btn_evt, query_evt;
    logic       grant_tmr, grant_btn, grant_qry, tx_grant;

    tx_state_e         tx_state_q;
    logic [CNT_W-1:0]  tx_cnt_q;
    logic [2:0]        tx_idx_q;
    logic [7:0]        tx_shift_q;
    logic              tx_line_q;
    logic [7:0]        tx_payload;

    rx_state_e         rx_state_q;
    logic [CNT_W-1:0]  rx_cnt_q;
    logic [2:0]        rx_idx_q;
    logic [7:0]        rx_shift_q;
    logic [7:0]        rx_byte_q;
    logic              rx_prev_q;
    logic              rx_fall;

    logic [3:0]        led_q;
    logic [3:0]        led_d;

    assign timer_evt = tmr_s & ~tmr_prev_q;
    assign btn_evt   = (btn_s2_q != prev_btn_q);
    assign query_evt = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && rx_s
                       && (rx_shift_q == 8'h3F);

    // Fixed priority grant, only while the transmitter is idle
    assign grant_tmr = (tx_state_q == TX_IDLE) & timer_pend_q;
    assign grant_btn = (tx_state_q == TX_IDLE) & ~timer_pend_q & btn_pend_q;
    assign grant_qry = (tx_state_q == TX_IDLE) & ~timer_pend_q & ~btn_pend_q & query_pend_q;
    assign tx_grant  = grant_tmr | grant_btn | grant_qry;

    // A fresh event in the grant cycle keeps its flag set
    assign timer_pend_d = (timer_pend_q & ~grant_tmr) | timer_evt;
    assign btn_pend_d   = (btn_pend_q   & ~grant_btn) | btn_evt;
    assign query_pend_d = (query_pend_q & ~grant_qry) | query_evt;

    always_comb begin
        tx_payload = {sw_s2_q, btn_s2_q};
        if (grant_tmr) begin
            tx_payload = {4'hA, tick_cnt_q};
        end else if (grant_btn) begin
            tx_payload = {4'hB, btn_val_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tmr_prev_q   <= 1'b0;
            prev_btn_q   <= 4'h0;
            btn_val_q    <= 4'h0;
            tick_cnt_q   <= 4'h0;
            timer_pend_q <= 1'b0;
            btn_pend_q   <= 1'b0;
            query_pend_q <= 1'b0;
        end else begin
            tmr_prev_q   <= tmr_s;
            timer_pend_q <= timer_pend_d;
            btn_pend_q   <= btn_pend_d;
            query_pend_q <= query_pend_d;
            if (timer_evt) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
            end
            if (btn_evt) begin
                prev_btn_q <= btn_s2_q;
                btn_val_q  <= btn_s2_q;
            end
        end
    end

    // LED display mode from the low two switches
    always_comb begin
        led_d = btn_s2_q;
        case (sw_s2_q[1:0])
            2'b00:   led_d = btn_s2_q;
            2'b01:   led_d = tick_cnt_q;
            2'b10:   led_d = rx_byte_q[3:0];
            default: led_d = btn_s2_q ^ sw_s2_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            led_q <= 4'h0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

    // UART transmitter, LSB first; the shift register drops one bit per data slot
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_line_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_line_q <= 1'b1;
                    if (tx_grant) begin
                        tx_shift_q <= tx_payload;
                        tx_cnt_q   <= '0;
                        tx_line_q  <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= 3'd0;
                        tx_line_q  <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'd7) begin
                            tx_line_q  <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_idx_q   <= tx_idx_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_line_q  <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    tx_line_q  <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx = tx_line_q;

    // UART receiver: start qualified at half bit, then mid-bit sampling
    assign rx_fall = rx_prev_q & ~rx_s;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_prev_q <= rx_s;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_idx_q   <= 3'd0;
                        rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        if (rx_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_s) begin
                            rx_byte_q <= rx_shift_q;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_soc_top.sv
// Directed bench for cpu_soc_top: a line monitor decodes UART frames and each
// scenario task compares LEDs and decoded bytes against hand-derived values.
module tb_cpu_soc_top;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       int_timer;
    logic [3:0] buttom;
    logic [3:0] switch;
    logic [3:0] led;
    logic       uart_rx;
    logic       uart_tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mq_byte[$];
    int         mq_start[$];
    bit         mq_stop[$];

    logic [7:0] mon_b;
    int         mon_st;
    bit         mon_stop;

    cpu_soc_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .int_timer (int_timer),
        .buttom    (buttom),
        .switch    (switch),
        .led       (led),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame decoder: detects the start bit, then samples each bit at its middle
    always begin
        @(negedge clk);
        if (uart_tx === 1'b0) begin
            mon_st = cyc;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            mon_stop = (uart_tx === 1'b1);
            mq_byte.push_back(mon_b);
            mq_start.push_back(mon_st);
            mq_stop.push_back(mon_stop);
        end
    end

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int k = 0;
        while (mq_byte.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (mq_byte.size() >= n);
    endtask

    task automatic pop_frame(output logic [7:0] b, output int st, output bit sok);
        b   = mq_byte.pop_front();
        st  = mq_start.pop_front();
        sok = mq_stop.pop_front();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        bit ok;
        logic [7:0] b;
        int st;
        bit sok;
        repeat (2) @(negedge clk);
        total++;
        if (led !== 4'h0) begin bad++; $display("FAIL reset_led got=%h exp=0", led); end
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
        rst_n = 1'b0;
        wait_frames(1, 400, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL reset_frame timeout got=%0d frames exp=1", mq_byte.size());
        end else begin
            pop_frame(b, st, sok);
            total++;
            if (b !== 8'hB1 || !sok) begin
                bad++; $display("FAIL reset_frame got=%h stop=%b exp=b1 stop=1", b, sok);
            end
        end
        total++;
        if (led !== 4'h0) begin bad++; $display("FAIL reset_led_rx got=%h exp=0", led); end
    endtask

    task automatic test_buttons();
        bit ok;
        logic [7:0] b;
        int st[3];
        bit sok;
        switch = 4'h0;
        for (int i = 0; i < 3; i++) begin
            buttom = 4'(i + 2);
            repeat (4) @(negedge clk);
            total++;
            if (led !== 4'(i + 2)) begin
                bad++; $display("FAIL btn_led%0d got=%h exp=%h", i, led, 4'(i + 2));
            end
            repeat (121) @(negedge clk);
        end
        wait_frames(3, 600, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL btn_frames timeout got=%0d frames exp=3", mq_byte.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                pop_frame(b, st[i], sok);
                total++;
                if (b !== 8'hB2 + 8'(i) || !sok) begin
                    bad++; $display("FAIL btn_frame%0d got=%h stop=%b exp=%h", i, b, sok, 8'hB2 + 8'(i));
                end
            end
            total++;
            if (st[2] - st[1] !== 161) begin
                bad++; $display("FAIL btn_gap got=%0d exp=161", st[2] - st[1]);
            end
        end
    endtask

    task automatic test_timer();
        bit ok;
        logic [7:0] b;
        int st;
        bit sok;
        switch = 4'h1;
        for (int i = 0; i < 3; i++) begin
            int_timer = 1'b1;
            repeat (2) @(negedge clk);
            int_timer = 1'b0;
            repeat (6) @(negedge clk);
            total++;
            if (led !== 4'(i + 1)) begin
                bad++; $display("FAIL tick_led%0d got=%h exp=%h", i, led, 4'(i + 1));
            end
            repeat (200) @(negedge clk);
        end
        wait_frames(3, 400, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL tick_frames timeout got=%0d frames exp=3", mq_byte.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                pop_frame(b, st, sok);
                total++;
                if (b !== 8'hA1 + 8'(i) || !sok) begin
                    bad++; $display("FAIL tick_frame%0d got=%h stop=%b exp=%h", i, b, sok, 8'hA1 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        logic [7:0] b0, b1;
        int st0, st1;
        bit s0, s1;
        int_timer = 1'b1;
        buttom    = 4'h5;
        repeat (2) @(negedge clk);
        int_timer = 1'b0;
        wait_frames(2, 500, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL prio_frames timeout got=%0d frames exp=2", mq_byte.size());
        end else begin
            pop_frame(b0, st0, s0);
            pop_frame(b1, st1, s1);
            total++;
            if (b0 !== 8'hA4 || b1 !== 8'hB5) begin
                bad++; $display("FAIL prio_order got=%h,%h exp=a4,b5", b0, b1);
            end
            total++;
            if (st1 - st0 !== 161) begin
                bad++; $display("FAIL prio_gap got=%0d exp=161", st1 - st0);
            end
        end
    endtask

    task automatic test_rx();
        bit ok;
        logic [7:0] b;
        int st;
        bit sok;
        switch = 4'h2;
        send_byte(8'h5C, 1'b1);
        total++;
        if (led !== 4'hC) begin bad++; $display("FAIL rx_led got=%h exp=c", led); end
        total++;
        if (mq_byte.size() !== 0) begin
            bad++; $display("FAIL rx_noreply got=%0d frames exp=0", mq_byte.size());
        end
        buttom = 4'h4;
        wait_frames(1, 400, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rx_btn timeout got=%0d frames exp=1", mq_byte.size());
        end else begin
            pop_frame(b, st, sok);
            total++;
            if (b !== 8'hB4) begin bad++; $display("FAIL rx_btn got=%h exp=b4", b); end
        end
        send_byte(8'h3F, 1'b1);
        total++;
        if (led !== 4'hF) begin bad++; $display("FAIL query_led got=%h exp=f", led); end
        wait_frames(1, 400, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL query timeout got=%0d frames exp=1", mq_byte.size());
        end else begin
            pop_frame(b, st, sok);
            total++;
            if (b !== 8'h24 || !sok) begin
                bad++; $display("FAIL query_reply got=%h stop=%b exp=24", b, sok);
            end
        end
    endtask

    task automatic test_rx_errors();
        send_byte(8'h5A, 1'b1);
        total++;
        if (led !== 4'hA) begin bad++; $display("FAIL err_setup_led got=%h exp=a", led); end
        send_byte(8'h12, 1'b0);
        total++;
        if (led !== 4'hA) begin bad++; $display("FAIL framing_led got=%h exp=a", led); end
        send_byte(8'h3F, 1'b0);
        total++;
        if (led !== 4'hA) begin bad++; $display("FAIL framing_q_led got=%h exp=a", led); end
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge clk);
        total++;
        if (led !== 4'hA) begin bad++; $display("FAIL glitch_led got=%h exp=a", led); end
        total++;
        if (mq_byte.size() !== 0) begin
            bad++; $display("FAIL err_noreply got=%0d frames exp=0", mq_byte.size());
        end
    endtask

    task automatic test_reset_mid_tx();
        int k = 0;
        int lows = 0;
        buttom = 4'h0;
        while (uart_tx !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (uart_tx !== 1'b0) begin
            bad++; $display("FAIL midtx_start timeout got=%b exp=0", uart_tx);
        end
        repeat (40) @(negedge clk);
        total++;
        if (uart_tx !== 1'b0) begin bad++; $display("FAIL midtx_bit1 got=%b exp=0", uart_tx); end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL midtx_abort got=%b exp=1", uart_tx); end
        total++;
        if (led !== 4'h0) begin bad++; $display("FAIL midtx_led got=%h exp=0", led); end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        total++;
        if (lows !== 0) begin bad++; $display("FAIL midtx_resume got=%0d low cycles exp=0", lows); end
    endtask

    initial begin
        rst_n     = 1'b1;
        int_timer = 1'b0;
        buttom    = 4'h1;
        switch    = 4'h2;
        uart_rx   = 1'b1;
        test_reset();
        test_buttons();
        test_timer();
        test_same_cycle();
        test_rx();
        test_rx_errors();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
